// File: rtl/tone_generator.sv
// tone_generator: periodic signed 16-bit square/triangle test-waveform source.
//
// One sample is produced every SMPL_DIV clk cycles while running. The
// configuration (mode, samples per half-cycle, peak-to-peak amplitude) is
// taken over a valid/ready handshake that is only ready in IDLE. For the
// triangle the per-sample slope step = floor((amp << FRAC) / half_per) is
// computed by a restoring divider, one quotient bit per cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_vld / cfg_rdy   configuration handshake (cfg_rdy high only in IDLE)
//   cfg_mode            0 = square, 1 = triangle
//   cfg_half_per        samples per half-cycle (0 is discarded)
//   cfg_amp             peak-to-peak amplitude (0 is discarded)
//   stop                leave RUN on the next edge (ignored while dividing)
//   busy                high while dividing or running
//   smpl, smpl_vld      signed sample and its one-cycle update strobe
//
// Optional build macro STEREO_OUT_EN adds smpl_rght, the saturating negation
// of smpl, registered alongside it.
module tone_generator #(
  parameter int unsigned SMPL_DIV = 1042,
  parameter int unsigned FRAC     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_vld,
  output logic        cfg_rdy,
  input  logic        cfg_mode,
  input  logic [15:0] cfg_half_per,
  input  logic [15:0] cfg_amp,
  input  logic        stop,
  output logic        busy,
  output logic [15:0] smpl,
  output logic        smpl_vld
`ifdef STEREO_OUT_EN
  ,
  output logic [15:0] smpl_rght
`endif
);

  localparam int unsigned QW = 16 + FRAC;  // dividend / quotient (step) width
  localparam int unsigned AW = 17 + FRAC;  // signed accumulator width
  localparam int unsigned TW = (SMPL_DIV > 1) ? $clog2(SMPL_DIV) : 1;
  localparam int unsigned CW = $clog2(QW + 1);

  typedef enum logic [1:0] {StIdle, StDiv, StRun} state_e;

  state_e                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [15:0]            half_per_q, half_per_d;
  logic [14:0]            peak_q, peak_d;
  logic [QW-1:0]          quo_q, quo_d;      // dividend in, quotient out; holds step in RUN
  logic [15:0]            rem_q, rem_d;
  logic [CW-1:0]          div_cnt_q, div_cnt_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [15:0]            hc_q, hc_d;
  logic                   rising_q, rising_d;  // rising (triangle) / high (square) half
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [15:0]            smpl_q, smpl_d;
  logic                   smpl_vld_q, smpl_vld_d;

  logic [16:0]            rem_shift;
  logic [15:0]            rem_diff;
  logic signed [AW-1:0]   peak_fix;
  logic signed [AW-1:0]   peak_fix_in;
  logic signed [AW-1:0]   step_ext;
  logic signed [AW-1:0]   acc_new;
  logic signed [16:0]     tri_raw;
  logic signed [16:0]     peak17;
  logic signed [16:0]     tri_clamped;
  logic [15:0]            sq_smpl;

  // Sample arithmetic for the next tick.
  always_comb begin
    peak_fix    = {2'b00, peak_q, {FRAC{1'b0}}};
    peak_fix_in = {2'b00, cfg_amp[15:1], {FRAC{1'b0}}};
    step_ext    = {1'b0, quo_q};
    // Snap at every half boundary so rounding in step never accumulates.
    if (hc_q == 16'd0) begin
      acc_new = rising_q ? -peak_fix : peak_fix;
    end else begin
      acc_new = rising_q ? (acc_q + step_ext) : (acc_q - step_ext);
    end
    // Upper bits are acc >>> FRAC, i.e. floor division.
    tri_raw = acc_new[AW-1:FRAC];
    peak17  = {2'b00, peak_q};
    if (tri_raw > peak17) begin
      tri_clamped = peak17;
    end else if (tri_raw < -peak17) begin
      tri_clamped = -peak17;
    end else begin
      tri_clamped = tri_raw;
    end
    sq_smpl = rising_q ? {1'b0, peak_q} : (16'd0 - {1'b0, peak_q});
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    half_per_d = half_per_q;
    peak_d     = peak_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    div_cnt_d  = div_cnt_q;
    tick_d     = tick_q;
    hc_d       = hc_q;
    rising_d   = rising_q;
    acc_d      = acc_q;
    smpl_d     = smpl_q;
    smpl_vld_d = 1'b0;
    rem_shift  = {rem_q, quo_q[QW-1]};
    rem_diff   = rem_shift[15:0] - half_per_q;

    unique case (state_q)
      StIdle: begin
        smpl_d = '0;
        // Zero half-period or amplitude is consumed but never started.
        if (cfg_vld && (cfg_half_per != 16'd0) && (cfg_amp != 16'd0)) begin
          mode_d     = cfg_mode;
          half_per_d = cfg_half_per;
          peak_d     = cfg_amp[15:1];
          if (cfg_mode) begin
            state_d   = StDiv;
            div_cnt_d = '0;
            rem_d     = '0;
            quo_d     = {cfg_amp, {FRAC{1'b0}}};
          end else begin
            state_d  = StRun;
            tick_d   = '0;
            hc_d     = '0;
            rising_d = 1'b1;
            acc_d    = -peak_fix_in;
          end
        end
      end

      StDiv: begin
        if (rem_shift >= {1'b0, half_per_q}) begin
          rem_d = rem_diff;
          quo_d = {quo_q[QW-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[15:0];
          quo_d = {quo_q[QW-2:0], 1'b0};
        end
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == CW'(QW - 1)) begin
          state_d  = StRun;
          tick_d   = '0;
          hc_d     = '0;
          rising_d = 1'b1;
          acc_d    = -peak_fix;
        end
      end

      StRun: begin
        if (stop) begin
          state_d = StIdle;
          smpl_d  = '0;
        end else if (tick_q == TW'(SMPL_DIV - 1)) begin
          tick_d     = '0;
          smpl_vld_d = 1'b1;
          smpl_d     = mode_q ? tri_clamped[15:0] : sq_smpl;
          acc_d      = acc_new;
          if (hc_q == half_per_q - 16'd1) begin
            hc_d     = '0;
            rising_d = ~rising_q;
          end else begin
            hc_d = hc_q + 16'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      half_per_q <= '0;
      peak_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      div_cnt_q  <= '0;
      tick_q     <= '0;
      hc_q       <= '0;
      rising_q   <= 1'b0;
      acc_q      <= '0;
      smpl_q     <= '0;
      smpl_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      half_per_q <= half_per_d;
      peak_q     <= peak_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      div_cnt_q  <= div_cnt_d;
      tick_q     <= tick_d;
      hc_q       <= hc_d;
      rising_q   <= rising_d;
      acc_q      <= acc_d;
      smpl_q     <= smpl_d;
      smpl_vld_q <= smpl_vld_d;
    end
  end

`ifdef STEREO_OUT_EN
  logic [15:0] smpl_rght_q, smpl_rght_d;

  always_comb begin
    smpl_rght_d = (smpl_d == 16'h8000) ? 16'h7fff : (16'd0 - smpl_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smpl_rght_q <= '0;
    end else begin
      smpl_rght_q <= smpl_rght_d;
    end
  end

  assign smpl_rght = smpl_rght_q;
`endif

  assign cfg_rdy  = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign smpl     = smpl_q;
  assign smpl_vld = smpl_vld_q;

endmodule

// File: tb/tb_tone_generator.sv
module tb_tone_generator;

  localparam int SMPL_DIV = 4;
  localparam int DIV_CYC  = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_vld = 1'b0;
  logic        cfg_rdy;
  logic        cfg_mode = 1'b0;
  logic [15:0] cfg_half_per = '0;
  logic [15:0] cfg_amp = '0;
  logic        stop = 1'b0;
  logic        busy;
  logic [15:0] smpl;
  logic        smpl_vld;
`ifdef STEREO_OUT_EN
  logic [15:0] smpl_rght;
`endif

  tone_generator #(
    .SMPL_DIV(SMPL_DIV),
    .FRAC    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_vld     (cfg_vld),
    .cfg_rdy     (cfg_rdy),
    .cfg_mode    (cfg_mode),
    .cfg_half_per(cfg_half_per),
    .cfg_amp     (cfg_amp),
    .stop        (stop),
    .busy        (busy),
    .smpl        (smpl),
    .smpl_vld    (smpl_vld)
`ifdef STEREO_OUT_EN
    ,
    .smpl_rght   (smpl_rght)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int cap[$];
  int expv[$];

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Closed-form sample n of a waveform, straight from the waveform rules.
  function automatic int model_val(input int mode, input int hp, input int amp, input int n);
    int p, h, k, step, a, v;
    p    = amp / 2;
    h    = (n / hp) % 2;
    k    = n % hp;
    step = (amp * 256) / hp;
    if (mode == 0) return (h == 0) ? p : -p;
    a = (h == 0) ? (-p * 256 + k * step) : (p * 256 - k * step);
    v = a >>> 8;
    if (v > p) v = p;
    if (v < -p) v = -p;
    return v;
  endfunction

  // Reference model: idle / dividing / running with a cycle count since entry.
  int m_st = 0, m_cyc = 0, m_n = 0, m_mode = 0, m_hp = 1, m_amp = 0, m_smpl = 0;
  bit m_vld = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = 0; m_cyc = 0; m_n = 0; m_smpl = 0; m_vld = 1'b0;
    end else begin
      m_vld = 1'b0;
      case (m_st)
        0: begin
          m_smpl = 0;
          if (cfg_vld && cfg_half_per != 0 && cfg_amp != 0) begin
            m_mode = int'(cfg_mode);
            m_hp   = int'(cfg_half_per);
            m_amp  = int'(cfg_amp);
            m_st   = cfg_mode ? 1 : 2;
            m_cyc  = 0;
            m_n    = 0;
          end
        end
        1: begin
          m_cyc++;
          if (m_cyc == DIV_CYC) begin
            m_st = 2; m_cyc = 0;
          end
        end
        default: begin
          if (stop) begin
            m_st = 0; m_smpl = 0;
          end else begin
            m_cyc++;
            if (m_cyc % SMPL_DIV == 0) begin
              m_smpl = model_val(m_mode, m_hp, m_amp, m_n);
              m_n++;
              m_vld = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      cmp("smpl", int'($signed(smpl)), m_smpl);
      cmp("smpl_vld", int'(smpl_vld), int'(m_vld));
      cmp("busy", int'(busy), (m_st != 0) ? 1 : 0);
      cmp("cfg_rdy", int'(cfg_rdy), (m_st == 0) ? 1 : 0);
`ifdef STEREO_OUT_EN
      cmp("smpl_rght", int'($signed(smpl_rght)), (m_smpl == -32768) ? 32767 : -m_smpl);
`endif
    end
  end

  task automatic send_cfg(input bit mode, input int hp, input int amp);
    @(negedge clk);
    cfg_mode     = mode;
    cfg_half_per = 16'(hp);
    cfg_amp      = 16'(amp);
    cfg_vld      = 1'b1;
    @(negedge clk);
    cfg_vld = 1'b0;
  endtask

  task automatic collect(input int n, input int budget);
    cap.delete();
    for (int i = 0; i < budget && cap.size() < n; i++) begin
      @(negedge clk);
      if (smpl_vld) cap.push_back(int'($signed(smpl)));
    end
    cmp("strobe_count", cap.size(), n);
  endtask

  task automatic check_seq(input string nm);
    for (int i = 0; i < expv.size() && i < cap.size(); i++) begin
      cmp($sformatf("%s[%0d]", nm, i), cap[i], expv[i]);
    end
  endtask

  task automatic first_strobe(output int lat, output int val);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!smpl_vld && lat < 100);
    val = int'($signed(smpl));
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  int lat, val;

  initial begin
    repeat (3) @(negedge clk);
    cmp("rst_smpl", int'(smpl), 0);
    cmp("rst_vld", int'(smpl_vld), 0);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_rdy", int'(cfg_rdy), 1);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Square, half_per 3, amp 1000.
    send_cfg(1'b0, 3, 1000);
    cmp("sq_busy", int'(busy), 1);
    cmp("sq_rdy", int'(cfg_rdy), 0);
    first_strobe(lat, val);
    cmp("sq_latency", lat, 4);
    cmp("sq_first", val, 500);
    collect(6, 60);
    expv = '{500, 500, -500, -500, -500, 500};
    check_seq("sq");
    do_stop();

    // Triangle exact, step 64000.
    send_cfg(1'b1, 4, 1000);
    first_strobe(lat, val);
    cmp("tri_latency", lat, DIV_CYC + 4);
    cmp("tri_first", val, -500);
    collect(8, 60);
    expv = '{-250, 0, 250, 500, 250, 0, -250, -500};
    check_seq("tri");
    do_stop();

    // Triangle with truncated step 8533, three full periods.
    send_cfg(1'b1, 3, 100);
    collect(18, 200);
    expv.delete();
    for (int r = 0; r < 3; r++) begin
      expv.push_back(-50); expv.push_back(-17); expv.push_back(16);
      expv.push_back(50);  expv.push_back(16);  expv.push_back(-17);
    end
    check_seq("trir");
    do_stop();

    // Illegal configs are consumed without leaving IDLE.
    send_cfg(1'b0, 0, 1000);
    cmp("hp0_rdy", int'(cfg_rdy), 1);
    cmp("hp0_busy", int'(busy), 0);
    send_cfg(1'b1, 5, 0);
    cmp("amp0_rdy", int'(cfg_rdy), 1);

    // cfg_vld held during RUN with a different config must be ignored.
    @(negedge clk);
    cfg_mode = 1'b0; cfg_half_per = 16'd3; cfg_amp = 16'd1000; cfg_vld = 1'b1;
    @(negedge clk);
    cfg_mode = 1'b1; cfg_half_per = 16'd1; cfg_amp = 16'd20000;
    collect(7, 60);
    cfg_vld = 1'b0;
    expv = '{500, 500, 500, -500, -500, -500, 500};
    check_seq("ign");

    // stop on the tick cycle: no strobe, IDLE with smpl 0.
    first_strobe(lat, val);
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    cmp("stop_vld", int'(smpl_vld), 0);
    cmp("stop_smpl", int'(smpl), 0);
    cmp("stop_rdy", int'(cfg_rdy), 1);

    // Extremes: full-scale square, half_per 1.
    send_cfg(1'b0, 1, 65535);
    collect(4, 40);
    expv = '{32767, -32767, 32767, -32767};
    check_seq("ext");
`ifdef STEREO_OUT_EN
    cmp("ext_rght", int'($signed(smpl_rght)), 32767);
`endif

    // Asynchronous reset in the middle of a tick.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    cmp("arst_smpl", int'(smpl), 0);
    cmp("arst_vld", int'(smpl_vld), 0);
    cmp("arst_rdy", int'(cfg_rdy), 1);
    cmp("arst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cmp("post_rst_rdy", int'(cfg_rdy), 1);
    cmp("post_rst_smpl", int'(smpl), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_generator.md
Name: tone_generator

Overview:
- Generates a periodic signed 16-bit test waveform, square or triangle, at a programmable half-period and peak-to-peak amplitude.
- Output runs at a fixed audio sample rate derived from clk.
- Serves as the stimulus source feeding the left/right channel inputs of the waveform measurement path, so it exercises frequency and amplitude measurement end to end.
- Configured through a valid/ready handshake; triangle slope is computed by an internal sequential divider.

Parameters:
- SMPL_DIV, 1042, clk cycles per output sample (50 MHz / 1042 ≈ 48 kHz); must be ≥ 2.
- FRAC, 8, fraction bits of the triangle accumulator and step.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- cfg_vld  in  1  configuration valid.
- cfg_rdy  out  1  configuration ready; high only in IDLE.
- cfg_mode  in  1  waveform select: 0 = square, 1 = triangle.
- cfg_half_per  in  16  samples per half-cycle, unsigned; 0 is illegal.
- cfg_amp  in  16  peak-to-peak amplitude, unsigned.
- stop  in  1  halt generation and return to IDLE.
- busy  out  1  high in DIV or RUN.
- smpl  out  16  signed output sample.
- smpl_vld  out  1  one-cycle strobe when smpl updates.

Behaviour:
- Reset (async, active-high): state = IDLE, smpl = 0, smpl_vld = 0, busy = 0, cfg_rdy = 1. All counters and the accumulator clear. Reset asserted mid-DIV or mid-RUN aborts immediately.
- Handshake: a config is accepted on a clk edge with cfg_vld && cfg_rdy. All cfg_* inputs are latched on acceptance.
  - cfg_half_per = 0 or cfg_amp = 0 is accepted but discarded; the block stays in IDLE.
  - cfg_vld outside IDLE is ignored.
- Peak level: P = cfg_amp >> 1, so the range is 0..32767.
- State IDLE: smpl = 0.
  - Accept with mode 0 -> RUN.
  - Accept with mode 1 -> DIV.
- State DIV: restoring divide, 1 bit per cycle, exactly 16+FRAC cycles.
  - step = floor((cfg_amp << FRAC) / cfg_half_per), 24 bits for FRAC = 8.
  - Then -> RUN.
  - stop is ignored in DIV.
- Entering RUN:
  - sample-tick counter = 0, half-cycle counter hc = 0.
  - phase = rising for triangle, high for square.
  - accumulator acc = -(P << FRAC).
- State RUN:
  - The tick counter counts 0..SMPL_DIV-1 and wraps.
  - At terminal count, smpl_vld = 1 for one cycle and smpl is registered with the new value in that same cycle. smpl holds between strobes.
  - The first strobe occurs SMPL_DIV cycles after entering RUN.
- Square: emit +P while high, -P while low. After cfg_half_per samples, hc wraps to 0 and the phase toggles.
- Triangle: emitted sample = acc >>> FRAC (arithmetic shift, floor), with acc 25-bit signed.
  - Rising half: sample 0 snaps acc to -(P << FRAC); each later sample does acc += step.
  - Falling half: sample 0 snaps acc to +(P << FRAC); each later sample does acc -= step.
  - Snapping at every half boundary prevents drift. No value may exceed ±P.
- Half-period wrap: hc runs 0..cfg_half_per-1. With cfg_half_per = 1 every sample alternates between +P and -P.
- stop in RUN: next edge -> IDLE, smpl = 0, no strobe that cycle.
  - If stop coincides with a tick, stop wins.
- Measured outputs: peak-to-peak = 2P; full period = 2*cfg_half_per samples.

Optional Feature:
- STEREO_OUT_EN: when defined, adds output smpl_rght (16-bit signed), registered alongside smpl, equal to the saturating negation of smpl (-(-32768) -> 32767; in practice never reached because |smpl| ≤ 32767). It resets to 0 and is 0 in IDLE.
- When undefined, the port and its logic are absent.

Test Plan:
- Reset (SMPL_DIV=4 in all tests): rst pulse in RUN mid-tick -> smpl=0, smpl_vld=0, cfg_rdy=1 asynchronously; then held in IDLE.
- Square: mode 0, half_per=3, amp=1000 -> strobes every 4 cycles, first 4 cycles after accept. Values: 500,500,500,-500,-500,-500,500...; busy=1, cfg_rdy=0.
- Triangle exact: mode 1, half_per=4, amp=1000 -> busy without strobes for 24 cycles (DIV), step=64000. Values: -500,-250,0,250,500,250,0,-250,-500...
- Triangle rounding: mode 1, half_per=3, amp=100 -> step=8533. Values: -50,-17,16,50,16,-17,-50, repeating identically over 3 periods (no drift).
- Illegal and ignored config: half_per=0 accepted -> stays IDLE. cfg_vld during RUN -> ignored, waveform unchanged. stop asserted on a tick cycle -> no strobe, IDLE next cycle, smpl=0.
- Extremes: mode 0, half_per=1, amp=65535 -> 32767,-32767 alternating. With STEREO_OUT_EN, smpl_rght = -32767,32767.
